mem_access_seq: RTL and testbench

- Sequences one CPU memory access through the MAR and MDR registers plus the external memory handshake.
- Sits between the control unit, which issues a request, and the MAR/MDR registers and the memory port.
- Generates the MARin, MDRin and MDR read-select enables and the mem_rd/mem_wr strobes.
- Returns a one-cycle done pulse when the access completes.

---
 rtl/mem_access_seq_pkg.sv | 56 +++++
 rtl/mem_access_seq_counter.sv | 41 ++++
 rtl/mem_access_seq.sv | 105 ++++++++++
 tb/tb_mem_access_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mem_access_seq_pkg.sv
//------------------------------------------------------------------------------
// mem_access_seq_pkg : shared state encodings, defaults and output decode
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mem_access_seq_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ADDR    = 3'd1;
    localparam logic [2:0] ST_WDATA   = 3'd2;
    localparam logic [2:0] ST_ACCESS  = 3'd3;
    localparam logic [2:0] ST_CAPTURE = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    localparam int DEF_MIN_WAIT = 0;
    localparam int DEF_TIMEOUT  = 255;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_ADDR    = ST_ADDR,
        S_WDATA   = ST_WDATA,
        S_ACCESS  = ST_ACCESS,
        S_CAPTURE = ST_CAPTURE,
        S_DONE    = ST_DONE
    } state_e;

    typedef struct packed {
        logic busy;
        logic done;
        logic err;
        logic mar_in;
        logic mdr_in;
        logic mdr_read;
        logic mem_rd;
        logic mem_wr;
    } ctl_t;

    // err is left clear here; only the timeout path in the FSM sets it
    function automatic ctl_t decode(input state_e s, input logic w);
        ctl_t c;
        c = '0;
        case (s)
            S_ADDR:    begin c.busy = 1'b1; c.mar_in = 1'b1; end
            S_WDATA:   begin c.busy = 1'b1; c.mdr_in = 1'b1; end
            S_ACCESS:  begin c.busy = 1'b1; c.mem_rd = ~w; c.mem_wr = w; end
            S_CAPTURE: begin c.busy = 1'b1; c.mdr_in = 1'b1; c.mdr_read = 1'b1; end
            S_DONE:    begin c.busy = 1'b1; c.done = 1'b1; end
            default:   c = '0;
        endcase
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_seq_counter.sv
//------------------------------------------------------------------------------
// mem_wait_counter : saturating ACCESS-cycle counter, clr has priority over inc
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_wait_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/mem_access_seq.sv
//------------------------------------------------------------------------------
// mem_access_seq : MAR/MDR + memory handshake sequencer for one CPU access.
// Optional MEM_TIMEOUT_EN aborts ACCESS after TIMEOUT cycles with err. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_access_seq
    import mem_access_seq_pkg::*;
#(
    parameter int MIN_WAIT = DEF_MIN_WAIT,
    parameter int CNT_W    = 8,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic clock,
    input  logic clear,
    input  logic req,
    input  logic wr,
    input  logic mem_ready,
    output logic busy,
    output logic done,
    output logic err,
    output logic MARin,
    output logic MDRin,
    output logic MDR_read,
    output logic mem_rd,
    output logic mem_wr
);

    state_e           state_q, state_d;
    logic             wr_q, wr_d;
    ctl_t             ctl_q, ctl_d;
    logic [CNT_W-1:0] count;
    logic             ready_ok;
    logic             tmo_hit;
    logic             timed_out;

    // Counter sits at zero outside ACCESS, so it is already cleared on entry
    mem_wait_counter #(.CNT_W(CNT_W)) u_wait_cnt (
        .clock (clock),
        .clear (clear),
        .clr   (state_q != S_ACCESS),
        .inc   (state_q == S_ACCESS),
        .count (count)
    );

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        timed_out = 1'b0;
        ready_ok  = mem_ready && (int'({1'b0, count}) >= MIN_WAIT);
`ifdef MEM_TIMEOUT_EN
        tmo_hit   = int'({1'b0, count}) >= (TIMEOUT - 1);
`else
        // TIMEOUT is non-negative, so ACCESS waits indefinitely
        tmo_hit   = (TIMEOUT < 0);
`endif
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    wr_d    = wr;
                    state_d = S_ADDR;
                end
            end
            S_ADDR:    state_d = wr_q ? S_WDATA : S_ACCESS;
            S_WDATA:   state_d = S_ACCESS;
            S_ACCESS: begin
                if (ready_ok) begin
                    state_d = wr_q ? S_DONE : S_CAPTURE;
                end else if (tmo_hit) begin
                    state_d   = S_DONE;
                    timed_out = 1'b1;
                end
            end
            S_CAPTURE: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        ctl_d     = decode(state_d, wr_d);
        ctl_d.err = timed_out;
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            ctl_q   <= ctl_d;
        end
    end

    assign busy     = ctl_q.busy;
    assign done     = ctl_q.done;
    assign err      = ctl_q.err;
    assign MARin    = ctl_q.mar_in;
    assign MDRin    = ctl_q.mdr_in;
    assign MDR_read = ctl_q.mdr_read;
    assign mem_rd   = ctl_q.mem_rd;
    assign mem_wr   = ctl_q.mem_wr;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_seq.sv
//------------------------------------------------------------------------------
// tb_mem_access_seq : two sequencers (MIN_WAIT 0 and 2) against a timeline model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_seq;

    localparam int MW0 = 0;
    localparam int MW1 = 2;
    localparam int TO  = 4;

    logic        clock = 1'b0;
    logic        clear;
    logic        req [2];
    logic        wr  [2];
    logic        rdy [2];
    logic [7:0]  ov  [2];   // {busy,done,err,MARin,MDRin,MDR_read,mem_rd,mem_wr}
    logic [31:0] bus, mdatain;
    logic [31:0] mdr  [2];
    logic [31:0] emdr [2];
    bit          emdr_ok [2];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clock = ~clock;

    mem_access_seq #(.MIN_WAIT(MW0), .CNT_W(8), .TIMEOUT(TO)) u_dut0 (
        .clock(clock), .clear(clear), .req(req[0]), .wr(wr[0]), .mem_ready(rdy[0]),
        .busy(ov[0][7]), .done(ov[0][6]), .err(ov[0][5]), .MARin(ov[0][4]),
        .MDRin(ov[0][3]), .MDR_read(ov[0][2]), .mem_rd(ov[0][1]), .mem_wr(ov[0][0])
    );

    mem_access_seq #(.MIN_WAIT(MW1), .CNT_W(8), .TIMEOUT(TO)) u_dut1 (
        .clock(clock), .clear(clear), .req(req[1]), .wr(wr[1]), .mem_ready(rdy[1]),
        .busy(ov[1][7]), .done(ov[1][6]), .err(ov[1][5]), .MARin(ov[1][4]),
        .MDRin(ov[1][3]), .MDR_read(ov[1][2]), .mem_rd(ov[1][1]), .mem_wr(ov[1][0])
    );

    // Behavioural MDR registers fed by each sequencer's enables
    always @(posedge clock) if (ov[0][3]) mdr[0] <= ov[0][2] ? mdatain : bus;
    always @(posedge clock) if (ov[1][3]) mdr[1] <= ov[1][2] ? mdatain : bus;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected output vector for cycle i after acceptance.
    // a = first ACCESS cycle, n = ACCESS cycles, dn = DONE cycle.
    function automatic logic [7:0] exp_vec(input int i, input bit w, input int n, input bit to);
        int a, dn;
        a  = w ? 3 : 2;
        dn = (w || to) ? a + n : a + n + 1;
        if (i == 1)                 return 8'b1001_0000;
        if (w && i == 2)            return 8'b1000_1000;
        if (i >= a && i < a + n)    return w ? 8'b1000_0001 : 8'b1000_0010;
        if (i == dn)                return {2'b11, to, 5'b0};
        if (!w && !to && i == a+n)  return 8'b1000_1100;
        return 8'h00;
    endfunction

    // Called at a negedge with DUT d idle; returns at a negedge with d idle again.
    task automatic run_txn(input int d, input bit w, input int nwait, input logic [31:0] data);
        int  mw, n, a, dn, k;
        bit  to;
        mw = (d == 1) ? MW1 : MW0;
        n  = mw + nwait + 1;
        to = 1'b0;
`ifdef MEM_TIMEOUT_EN
        if (n > TO) begin
            n  = TO;
            to = 1'b1;
        end
`endif
        a  = w ? 3 : 2;
        dn = (w || to) ? a + n : a + n + 1;
        req[d] = 1'b1;
        wr[d]  = w;
        rdy[d] = 1'($urandom);
        @(posedge clock);
        for (int i = 1; i <= dn; i++) begin
            @(negedge clock);
            check($sformatf("d%0d w%0d nw%0d cyc%0d", d, w, nwait, i), {24'h0, ov[d]},
                  {24'h0, exp_vec(i, w, n, to)});
            req[d]  = 1'($urandom);
            wr[d]   = 1'($urandom);
            rdy[d]  = 1'($urandom);
            bus     = $urandom;
            mdatain = $urandom;
            if (i >= a && i < a + n) begin
                k = i - a + 1;
                if (k > mw) rdy[d] = (k > mw + nwait);
            end
            if (w && i == 2) begin
                bus = data; mdatain = ~data;
            end
            if (!w && !to && i == a + n) begin
                mdatain = data; bus = ~data;
            end
        end
        @(negedge clock);
        check($sformatf("d%0d idle after done", d), {24'h0, ov[d]}, 32'h0);
        req[d] = 1'b0;
        rdy[d] = 1'($urandom);
        if (!to) begin
            emdr[d]    = data;
            emdr_ok[d] = 1'b1;
        end
        if (emdr_ok[d]) check($sformatf("d%0d mdr", d), mdr[d], emdr[d]);
    endtask

    initial begin
        bit bad;
        int d;
        clear   = 1'b1;
        bus     = '0;
        mdatain = '0;
        emdr_ok = '{1'b0, 1'b0};
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; wr[i] = 1'b0; rdy[i] = 1'b0;
        end
        #12;
        @(negedge clock);
        check("reset d0", {24'h0, ov[0]}, 32'h0);
        check("reset d1", {24'h0, ov[1]}, 32'h0);
        clear = 1'b0;

        // Abandon a read mid-ACCESS with an asynchronous clear
        req[0] = 1'b1; wr[0] = 1'b0; rdy[0] = 1'b0;
        @(negedge clock); req[0] = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("in access", {24'h0, ov[0]}, 32'h82);
        #2 clear = 1'b1;
        #1 check("async clear d0", {24'h0, ov[0]}, 32'h0);
        check("async clear d1", {24'h0, ov[1]}, 32'h0);
        @(negedge clock);
        clear = 1'b0;
        check("idle after clear", {24'h0, ov[0]}, 32'h0);

        run_txn(0, 1'b0, 0, 32'hDEADBEEF);
        run_txn(1, 1'b1, 0, 32'h0000_00A5);
        run_txn(0, 1'b0, 5, 32'h1234_5678);
        run_txn(0, 1'b0, 0, 32'hCAFE_0001);
        run_txn(0, 1'b1, 1, 32'hCAFE_0002);

`ifdef MEM_TIMEOUT_EN
        run_txn(0, 1'b0, 10, 32'h5555_AAAA);
        run_txn(1, 1'b1, 10, 32'h0F0F_0F0F);
`else
        // Without a timeout, ACCESS with mem_ready low never ends
        bad = 1'b0;
        req[0] = 1'b1; wr[0] = 1'b0; rdy[0] = 1'b0;
        repeat (110) begin
            @(negedge clock);
            req[0] = 1'($urandom);
            if (ov[0][6] || ov[0][5]) bad = 1'b1;
        end
        check("long wait busy", {31'h0, ov[0][7]}, 32'h1);
        check("long wait no done/err", {31'h0, bad}, 32'h0);
        #2 clear = 1'b1;
        #2 clear = 1'b0;
        req[0] = 1'b0;
        @(negedge clock);
        check("idle after long wait", {24'h0, ov[0]}, 32'h0);
`endif

        repeat (40) begin
            d = int'($urandom_range(1, 0));
            run_txn(d, 1'($urandom), int'($urandom_range(6, 0)), $urandom);
            repeat ($urandom_range(2, 0)) begin
                rdy[0] = 1'($urandom); rdy[1] = 1'($urandom);
                @(negedge clock);
                check("random idle d0", {24'h0, ov[0]}, 32'h0);
                check("random idle d1", {24'h0, ov[1]}, 32'h0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
